// File: rtl/rows_pkg.sv
// Shared widths, FSM state codes and the thermometer-code decoder used by the
// level-sensor row encoder.
package rows_pkg;

    localparam int ROWS_W  = 7;
    localparam int LEVEL_W = 3;

    localparam logic [1:0] STEADY = 2'd0;
    localparam logic [1:0] RISING = 2'd1;
    localparam logic [1:0] FAULT  = 2'd2;

    typedef struct packed {
        logic               valid;
        logic [LEVEL_W-1:0] level;
    } thermo_t;

    // A thermometer code plus one is a power of two (or wraps to zero at all-ones).
    function automatic thermo_t thermo_level(input logic [ROWS_W-1:0] pattern);
        thermo_t r;
        r.valid = ((pattern & (pattern + ROWS_W'(1))) == '0);
        r.level = '0;
        for (int i = 0; i < ROWS_W; i++) begin
            r.level = r.level + LEVEL_W'(pattern[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/rows_encoder_debounce.sv
// Two-flop synchroniser and stability filter for the raw sensor vector; emits a
// one-cycle accept when a new pattern has been stable long enough.
module sensor_debounce
    import rows_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS_W-1:0] sensors_in,
    input  logic              long_hold,
    output logic              accept_pulse,
    output logic [ROWS_W-1:0] accepted_pattern
);

    localparam int CNT_W = $clog2(2 * STABLE_CYCLES);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(2 * STABLE_CYCLES - 1);

    logic [ROWS_W-1:0] sync1;
    logic [ROWS_W-1:0] sync2;
    logic [ROWS_W-1:0] candidate;
    logic [ROWS_W-1:0] last_pattern;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  last_cnt;
    logic              stable;

    assign last_cnt         = long_hold ? LONG_LAST : SHORT_LAST;
    assign stable           = (sync2 == candidate) && (stable_cnt >= last_cnt);
    // Holding an already-accepted pattern must not generate further events.
    assign accept_pulse     = stable && (candidate != last_pattern);
    assign accepted_pattern = candidate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            candidate    <= '0;
            last_pattern <= '0;
            stable_cnt   <= '0;
        end else begin
            sync1 <= sensors_in;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate  <= sync2;
                stable_cnt <= '0;
            end else if (stable_cnt < last_cnt) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            if (accept_pulse) begin
                last_pattern <= candidate;
            end
        end
    end

endmodule

// File: rtl/rows_encoder.sv
// Level-sensor to {blink, count} encoder for the bar-display row decoder.
// Define LEVEL_HYST_EN to require twice the stability time for downward level changes.
//
// state  | meaning
// STEADY | level shown solid, blink off, divider idle
// RISING | level just rose; next segment flashes for BLINK_REPEAT periods
// FAULT  | non-thermometer pattern accepted; blink free-runs, count held
module rows_encoder
    import rows_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int BLINK_DIV     = 25000000,
    parameter int BLINK_REPEAT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ROWS_W-1:0]  sensors_in,
    output logic [LEVEL_W-1:0] count,
    output logic               blink,
    output logic               fault,
    output logic               level_change
);

    localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int REP_W = $clog2(BLINK_REPEAT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(BLINK_REPEAT - 1);

    logic              accept_pulse;
    logic [ROWS_W-1:0] accepted_pattern;
    logic              long_hold;
    thermo_t           cand;
    logic [1:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              div_tc;

    assign cand   = thermo_level(accepted_pattern);
    assign div_tc = (div_cnt == DIV_LAST);

`ifdef LEVEL_HYST_EN
    assign long_hold = cand.valid && (cand.level < count);
`else
    assign long_hold = 1'b0;
`endif

    sensor_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .clk             (clk),
        .rst             (rst),
        .sensors_in      (sensors_in),
        .long_hold       (long_hold),
        .accept_pulse    (accept_pulse),
        .accepted_pattern(accepted_pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= STEADY;
            count        <= '0;
            blink        <= 1'b0;
            fault        <= 1'b0;
            level_change <= 1'b0;
            div_cnt      <= '0;
            rep_cnt      <= '0;
        end else begin
            level_change <= 1'b0;
            if (accept_pulse) begin
                // An accept always restarts the flash timing, even on a divider terminal count.
                div_cnt <= '0;
                rep_cnt <= '0;
                if (!cand.valid) begin
                    fault <= 1'b1;
                    state <= FAULT;
                    blink <= 1'b1;
                end else begin
                    fault <= 1'b0;
                    if (cand.level != count) begin
                        count        <= cand.level;
                        level_change <= 1'b1;
                    end
                    // Full scale has no segment above it to flash.
                    if ((cand.level > count) && (cand.level != LEVEL_W'(ROWS_W))) begin
                        state <= RISING;
                        blink <= 1'b1;
                    end else begin
                        state <= STEADY;
                        blink <= 1'b0;
                    end
                end
            end else begin
                case (state)
                    RISING, FAULT: begin
                        if (div_tc) begin
                            div_cnt <= '0;
                            blink   <= ~blink;
                            if ((state == RISING) && blink) begin
                                if (rep_cnt == REP_LAST) begin
                                    state   <= STEADY;
                                    blink   <= 1'b0;
                                    rep_cnt <= '0;
                                end else begin
                                    rep_cnt <= rep_cnt + 1'b1;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= STEADY;
                        blink   <= 1'b0;
                        div_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rows_encoder.sv
// Directed bench for rows_encoder: a per-edge sample-history model predicts every
// output, plus literal checks on latency, flash shape, fault and async reset.
module tb_rows_encoder;

    localparam int S = 4;
    localparam int D = 4;
    localparam int R = 2;
`ifdef LEVEL_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif
    localparam int LAT_UP   = S + 2;
    localparam int LAT_DOWN = HYST ? 2 * S + 2 : S + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] sensors_in = '0;
    logic [2:0] count;
    logic       blink;
    logic       fault;
    logic       level_change;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    rows_encoder #(
        .STABLE_CYCLES(S),
        .BLINK_DIV    (D),
        .BLINK_REPEAT (R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensors_in  (sensors_in),
        .count       (count),
        .blink       (blink),
        .fault       (fault),
        .level_change(level_change)
    );

    // Model: every sampled input is kept; a pattern is accepted once it has been
    // seen for thr+1 consecutive samples ending two edges ago (synchroniser delay).
    logic [6:0] samples[$];
    int         m_count = 0;
    int         m_mode  = 0;   // 0 solid, 1 flashing after rise, 2 fault
    int         m_t     = 0;   // edges since the last flash restart
    bit         m_fault = 1'b0;
    bit         m_lc    = 1'b0;
    logic [6:0] m_last  = '0;

    function automatic logic [6:0] sample_at(int j);
        if (j < 0 || j >= samples.size()) return 7'd0;
        return samples[j];
    endfunction

    function automatic int level_of(logic [6:0] p);
        for (int n = 0; n <= 7; n++) begin
            if (p == 7'((1 << n) - 1)) return n;
        end
        return -1;
    endfunction

    function automatic bit exp_blink();
        if (m_mode == 1) return (m_t < 2 * R * D) && ((m_t / D) % 2 == 0);
        if (m_mode == 2) return ((m_t / D) % 2 == 0);
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int         k;
        int         run;
        int         lvl;
        int         thr;
        logic [6:0] v;
        if (rst) begin
            samples.delete();
            m_count = 0;
            m_mode  = 0;
            m_t     = 0;
            m_fault = 1'b0;
            m_lc    = 1'b0;
            m_last  = '0;
        end else begin
            samples.push_back(sensors_in);
            k    = samples.size() - 1;
            m_lc = 1'b0;
            m_t++;
            v   = sample_at(k - 2);
            run = 0;
            for (int j = k - 2; j >= k - 2 - 2 * S - 2; j--) begin
                if (sample_at(j) != v) break;
                run++;
            end
            lvl = level_of(v);
            thr = (HYST && lvl >= 0 && lvl < m_count) ? 2 * S : S;
            if (run >= thr + 1 && v != m_last) begin
                m_last = v;
                if (lvl < 0) begin
                    m_fault = 1'b1;
                    m_mode  = 2;
                    m_t     = 0;
                end else begin
                    m_fault = 1'b0;
                    if (lvl != m_count) m_lc = 1'b1;
                    if (lvl > m_count && lvl < 7) begin
                        m_mode = 1;
                        m_t    = 0;
                    end else begin
                        m_mode = 0;
                    end
                    m_count = lvl;
                end
            end
            if (m_mode == 1 && m_t >= 2 * R * D) m_mode = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            check("model_count", 32'(count), 32'(m_count));
            check("model_blink", 32'(blink), 32'(exp_blink()));
            check("model_fault", 32'(fault), 32'(m_fault));
            check("model_level_change", 32'(level_change), 32'(m_lc));
        end
    end

    // Drive p; count must still be old after lat edges and new on the next one.
    task automatic lat_check(input string name, input logic [6:0] p, input int old_lvl,
                             input int new_lvl, input int lat);
        @(negedge clk);
        sensors_in = p;
        repeat (lat) @(posedge clk);
        @(negedge clk);
        check({name, "_before"}, 32'(count), 32'(old_lvl));
        check({name, "_quiet"}, 32'(level_change), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_after"}, 32'(count), 32'(new_lvl));
        check({name, "_pulse"}, 32'(level_change), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        started = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_count", 32'(count), 32'd0);
        check("reset_blink", 32'(blink), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_pulse", 32'(level_change), 32'd0);

        lat_check("rise3", 7'b0000111, 0, 3, LAT_UP);
        check("rise3_blink_on", 32'(blink), 32'd1);
        repeat (4) @(negedge clk);
        check("rise3_blink_off", 32'(blink), 32'd0);
        repeat (4) @(negedge clk);
        check("rise3_blink_on2", 32'(blink), 32'd1);
        repeat (4) @(negedge clk);
        check("rise3_blink_done", 32'(blink), 32'd0);
        repeat (10) @(negedge clk);
        check("rise3_steady", 32'(blink), 32'd0);

        sensors_in = 7'b0001111;
        repeat (3) @(negedge clk);
        sensors_in = 7'b0000111;
        repeat (15) @(negedge clk);
        check("glitch_count", 32'(count), 32'd3);

        lat_check("full7", 7'b1111111, 3, 7, LAT_UP);
        check("full7_blink", 32'(blink), 32'd0);
        repeat (20) @(negedge clk);
        check("full7_blink_later", 32'(blink), 32'd0);

        lat_check("down4", 7'b0001111, 7, 4, LAT_DOWN);
        repeat (5) @(negedge clk);

        sensors_in = 7'b0010111;
        repeat (S + 3) @(negedge clk);
        check("fault_set", 32'(fault), 32'd1);
        check("fault_count", 32'(count), 32'd4);
        check("fault_blink_on", 32'(blink), 32'd1);
        repeat (4) @(negedge clk);
        check("fault_blink_off", 32'(blink), 32'd0);
        repeat (4) @(negedge clk);
        check("fault_blink_on2", 32'(blink), 32'd1);
        repeat (12) @(negedge clk);

        lat_check("recover2", 7'b0000011, 4, 2, LAT_DOWN);
        check("recover2_fault", 32'(fault), 32'd0);
        check("recover2_blink", 32'(blink), 32'd0);
        repeat (5) @(negedge clk);

        lat_check("rise5", 7'b0011111, 2, 5, LAT_UP);
        repeat (5) @(negedge clk);
        lat_check("rise6", 7'b0111111, 5, 6, LAT_UP);
        check("rise6_restart", 32'(blink), 32'd1);
        repeat (2) @(negedge clk);

        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_blink", 32'(blink), 32'd0);
        check("async_fault", 32'(fault), 32'd0);
        check("async_pulse", 32'(level_change), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("reaccept_count", 32'(count), 32'd6);

        lat_check("down1", 7'b0000001, 6, 1, LAT_DOWN);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
